scr1_ahb_tb_mem_mp: RTL



---
 rtl/scr1_tb_mem_pkg.sv | 41 ++++
 rtl/scr1_ahb_tb_mem_port.sv | 158 +++++++++++++++
 rtl/scr1_ahb_tb_mem_mp.sv | 116 +++++++++++
 3 files changed

// File: rtl/scr1_tb_mem_pkg.sv
// Shared types and helpers for the multi-port AHB-Lite testbench memory.
// Port FSM states, stall modes, HTRANS codes, LFSR taps and lane decode.
package scr1_tb_mem_pkg;

    typedef enum logic [1:0] {
        STALL_NONE   = 2'd0,
        STALL_FIXED  = 2'd1,
        STALL_RANDOM = 2'd2,
        STALL_RSVD   = 2'd3
    } stall_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } port_state_e;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Right-shifting Fibonacci form: taps 16,14,13,11 sit at bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            3'd0:    be = 4'b0001 << addr_lo;
            3'd1:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/scr1_ahb_tb_mem_port.sv
// One AHB-Lite slave port: transfer FSM, wait-state counter, LFSR and error decode.
// state   | meaning
// IDLE    | no data phase pending, ready for an address phase
// WAIT    | injected wait states, counter runs down to 1
// DATA    | data phase completes this cycle (read data / write commit)
// ERR1    | first error cycle, hready low
// ERR2    | second error cycle, hready high
module scr1_ahb_tb_mem_port
    import scr1_tb_mem_pkg::*;
#(
    parameter int                   AHB_WIDTH      = 32,
    parameter int                   MEM_POWER_SIZE = 20,
    parameter int                   STALL_W        = 4,
    parameter logic [AHB_WIDTH-1:0] ERR_BASE       = 32'hFFFF_0000,
    parameter logic [AHB_WIDTH-1:0] ERR_MASK       = 32'hFFFF_0000,
    parameter logic [AHB_WIDTH-1:0] SOFT_IRQ_ADDR  = 32'hF000_0000,
    parameter logic [15:0]          SEED           = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                htrans,
    input  logic [2:0]                hsize,
    input  logic [AHB_WIDTH-1:0]      haddr,
    input  logic                      hwrite,
    input  logic [AHB_WIDTH-1:0]      hwdata,
    input  logic [1:0]                stall_mode,
    input  logic [STALL_W-1:0]        stall_cycles,
    input  logic [AHB_WIDTH-1:0]      rd_word,
    output logic                      hready,
    output logic                      hresp,
    output logic [AHB_WIDTH-1:0]      hrdata,
    output logic                      wr_en,
    output logic                      irq_wr,
    output logic [MEM_POWER_SIZE-3:0] wr_idx,
    output logic [3:0]                wr_be,
    output logic [AHB_WIDTH-1:0]      wr_data,
    output logic [MEM_POWER_SIZE-3:0] rd_idx,
    output logic                      rd_irq
);

    port_state_e               state_q, state_d;
    logic [STALL_W-1:0]        cnt_q, cnt_d;
    logic [15:0]               lfsr_q, lfsr_d;
    logic [MEM_POWER_SIZE-3:0] idx_q, idx_d;
    logic [3:0]                be_q, be_d;
    logic                      write_q, write_d;
    logic                      irq_q, irq_d;
    logic                      hready_q, hready_d;
    logic                      hresp_q, hresp_d;
    logic [AHB_WIDTH-1:0]      hrdata_q, hrdata_d;

    logic               accept;
    logic               addr_err;
    logic               data_rd;
    logic [STALL_W-1:0] stall_s;

    always_comb begin
        accept   = hready_q && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
        addr_err = ((haddr & ERR_MASK) == ERR_BASE) || (hsize > 3'd2)
                || ((hsize == 3'd1) && haddr[0])
                || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
        data_rd  = (state_q == ST_DATA) && !write_q;

        case (stall_mode)
            STALL_FIXED:  stall_s = stall_cycles;
            STALL_RANDOM: stall_s = lfsr_q[STALL_W-1:0] & stall_cycles;
            default:      stall_s = '0;
        endcase

        state_d  = state_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        idx_d    = idx_q;
        be_d     = be_q;
        write_d  = write_q;
        irq_d    = irq_q;
        hrdata_d = hrdata_q;

        if (data_rd) begin
            hrdata_d = rd_word;
        end

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == STALL_W'(1)) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        // Address phase overlaps the data phase of the previous transfer.
        if (accept) begin
            if (stall_mode == STALL_RANDOM) begin
                lfsr_d = lfsr_next(lfsr_q);
            end
            idx_d   = haddr[MEM_POWER_SIZE-1:2];
            be_d    = byte_en(hsize, haddr[1:0]);
            write_d = hwrite;
            irq_d   = (haddr == SOFT_IRQ_ADDR);
            if (addr_err) begin
                state_d = ST_ERR1;
                cnt_d   = '0;
            end else if (stall_s != '0) begin
                state_d = ST_WAIT;
                cnt_d   = stall_s;
            end else begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
        end

        hready_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        hresp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            lfsr_q   <= SEED;
            idx_q    <= '0;
            be_q     <= '0;
            write_q  <= 1'b0;
            irq_q    <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            idx_q    <= idx_d;
            be_q     <= be_d;
            write_q  <= write_d;
            irq_q    <= irq_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign hready  = hready_q;
    assign hresp   = hresp_q;
    assign hrdata  = data_rd ? rd_word : hrdata_q;
    assign wr_en   = (state_q == ST_DATA) && write_q && !irq_q;
    assign irq_wr  = (state_q == ST_DATA) && write_q && irq_q;
    assign wr_idx  = idx_q;
    assign wr_be   = be_q;
    assign wr_data = hwdata;
    assign rd_idx  = idx_q;
    assign rd_irq  = irq_q;

endmodule

// File: rtl/scr1_ahb_tb_mem_mp.sv
// Multi-port AHB-Lite testbench memory: shared word array, ordered commits,
// per-port read mux and the soft-IRQ register.
module scr1_ahb_tb_mem_mp
    import scr1_tb_mem_pkg::*;
#(
    parameter int                   N_PORTS        = 2,
    parameter int                   AHB_WIDTH      = 32,
    parameter int                   MEM_POWER_SIZE = 20,
    parameter int                   STALL_W        = 4,
    parameter logic [AHB_WIDTH-1:0] ERR_BASE       = 32'hFFFF_0000,
    parameter logic [AHB_WIDTH-1:0] ERR_MASK       = 32'hFFFF_0000,
    parameter logic [AHB_WIDTH-1:0] SOFT_IRQ_ADDR  = 32'hF000_0000,
    parameter logic [15:0]          LFSR_SEED      = 16'hACE1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_PORTS-1:0][1:0]             htrans,
    input  logic [N_PORTS-1:0][2:0]             hsize,
    input  logic [N_PORTS-1:0][AHB_WIDTH-1:0]   haddr,
    input  logic [N_PORTS-1:0]                  hwrite,
    input  logic [N_PORTS-1:0][AHB_WIDTH-1:0]   hwdata,
    output logic [N_PORTS-1:0]                  hready,
    output logic [N_PORTS-1:0][AHB_WIDTH-1:0]   hrdata,
    output logic [N_PORTS-1:0]                  hresp,
    input  logic [N_PORTS-1:0][1:0]             stall_mode,
    input  logic [N_PORTS-1:0][STALL_W-1:0]     stall_cycles,
    output logic                                soft_irq
);

    localparam int IDX_W = MEM_POWER_SIZE - 2;

    logic [AHB_WIDTH-1:0] mem_q [0:(1 << IDX_W)-1];
    logic                 soft_irq_q, soft_irq_d;

    logic [N_PORTS-1:0]                wr_en;
    logic [N_PORTS-1:0]                irq_wr;
    logic [N_PORTS-1:0]                rd_irq;
    logic [N_PORTS-1:0][IDX_W-1:0]     wr_idx;
    logic [N_PORTS-1:0][IDX_W-1:0]     rd_idx;
    logic [N_PORTS-1:0][3:0]           wr_be;
    logic [N_PORTS-1:0][AHB_WIDTH-1:0] wr_data;
    logic [N_PORTS-1:0][AHB_WIDTH-1:0] rd_word;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        scr1_ahb_tb_mem_port #(
            .AHB_WIDTH      (AHB_WIDTH),
            .MEM_POWER_SIZE (MEM_POWER_SIZE),
            .STALL_W        (STALL_W),
            .ERR_BASE       (ERR_BASE),
            .ERR_MASK       (ERR_MASK),
            .SOFT_IRQ_ADDR  (SOFT_IRQ_ADDR),
            .SEED           (LFSR_SEED ^ 16'(p + 1))
        ) u_port (
            .clk          (clk),
            .rst_n        (rst_n),
            .htrans       (htrans[p]),
            .hsize        (hsize[p]),
            .haddr        (haddr[p]),
            .hwrite       (hwrite[p]),
            .hwdata       (hwdata[p]),
            .stall_mode   (stall_mode[p]),
            .stall_cycles (stall_cycles[p]),
            .rd_word      (rd_word[p]),
            .hready       (hready[p]),
            .hresp        (hresp[p]),
            .hrdata       (hrdata[p]),
            .wr_en        (wr_en[p]),
            .irq_wr       (irq_wr[p]),
            .wr_idx       (wr_idx[p]),
            .wr_be        (wr_be[p]),
            .wr_data      (wr_data[p]),
            .rd_idx       (rd_idx[p]),
            .rd_irq       (rd_irq[p])
        );
    end

    // Reads see the array as of the start of the cycle, so same-edge commits are not visible.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            rd_word[p] = rd_irq[p] ? {{(AHB_WIDTH-1){1'b0}}, soft_irq_q} : mem_q[rd_idx[p]];
        end
    end

    // Later NBAs override earlier ones, so the highest port index wins a shared byte.
    always_ff @(posedge clk) begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (wr_en[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[p][b]) begin
                        mem_q[wr_idx[p]][b*8 +: 8] <= wr_data[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        soft_irq_d = soft_irq_q;
        for (int p = 0; p < N_PORTS; p++) begin
            if (irq_wr[p]) begin
                soft_irq_d = wr_data[p][0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            soft_irq_q <= 1'b0;
        end else begin
            soft_irq_q <= soft_irq_d;
        end
    end

    assign soft_irq = soft_irq_q;

endmodule
